// File: rtl/ring_tdm_arbiter.sv
// ring_tdm_arbiter: two requesters (domain 0 / domain 1) share one ring link
// through a fixed time-division schedule. Each domain owns a 2-entry FIFO.
// The link only ever serves the queue of the domain owning the current slot,
// so neither domain can influence the timing seen by the other.
module ring_tdm_arbiter #(
  parameter int p_nbits       = 32,
  parameter int p_slot_cycles = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in0_val,
  output logic               in0_rdy,
  input  logic [p_nbits-1:0] in0_msg,
  input  logic               in1_val,
  output logic               in1_rdy,
  input  logic [p_nbits-1:0] in1_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic               out_domain,
  output logic [7:0]         slot_cnt
);

  logic               dom;
  logic [7:0]         cnt_r;
  logic [1:0]         q_cnt  [2];
  logic [p_nbits-1:0] q_data [2][2];
  logic [1:0]         val_in;
  logic [p_nbits-1:0] msg_in [2];
  logic [1:0]         enq;
  logic [1:0]         deq;
  logic [1:0]         rdy;

  // Handshake decode. All outputs are driven from registered state plus
  // out_rdy only; nothing from the input side reaches out_msg/out_val
  // combinationally. Reset forces the idle view (no valid, ready asserted)
  // while no handshake is allowed to take effect.
  always_comb begin
    val_in    = {in1_val, in0_val};
    msg_in[0] = in0_msg;
    msg_in[1] = in1_msg;
    out_val   = reset && (q_cnt[dom] != 2'd0);
    out_msg   = out_val ? q_data[dom][0] : '0;
    enq       = '0;
    deq       = '0;
    rdy       = '0;
    for (int d = 0; d < 2; d++) begin
      deq[d] = out_val && out_rdy && (dom == 1'(d));
      rdy[d] = !reset || (q_cnt[d] != 2'd2) || deq[d];
      enq[d] = reset && val_in[d] && rdy[d];
    end
  end

  assign in0_rdy    = rdy[0];
  assign in1_rdy    = rdy[1];
  assign out_domain = dom;
  assign slot_cnt   = cnt_r;

  // Control state: free-running slot schedule and queue occupancies.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r    <= '0;
      dom      <= 1'b0;
      q_cnt[0] <= '0;
      q_cnt[1] <= '0;
    end else begin
      if (cnt_r == 8'(p_slot_cycles - 1)) begin
        cnt_r <= '0;
        dom   <= ~dom;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
      for (int d = 0; d < 2; d++) begin
        case ({enq[d], deq[d]})
          2'b10:   q_cnt[d] <= q_cnt[d] + 2'd1;
          2'b01:   q_cnt[d] <= q_cnt[d] - 2'd1;
          default: q_cnt[d] <= q_cnt[d];
        endcase
      end
    end
  end

  // Queue storage: entry 0 is always the head; a dequeue shifts entry 1 down.
  always_ff @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (enq[d] && deq[d]) begin
        if (q_cnt[d] == 2'd2) begin
          q_data[d][0] <= q_data[d][1];
          q_data[d][1] <= msg_in[d];
        end else begin
          q_data[d][0] <= msg_in[d];
        end
      end else if (enq[d]) begin
        q_data[d][q_cnt[d][0]] <= msg_in[d];
      end else if (deq[d]) begin
        q_data[d][0] <= q_data[d][1];
      end
    end
  end

  // Simulation check: handshake controls must be known outside reset.
  always @(posedge clk) begin
    if (reset === 1'b1)
      assert (!$isunknown({in0_val, in1_val, out_rdy}))
        else $error("ring_tdm_arbiter: X on in0_val/in1_val/out_rdy");
  end

endmodule

// File: tb/tb_ring_tdm_arbiter.sv
// Bench for ring_tdm_arbiter: directed scenarios with literal expectations,
// plus a queue-based reference model compared against the DUT every cycle.
module tb_ring_tdm_arbiter;
  localparam int NB = 32;
  localparam int P  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in0_val = 1'b0, in1_val = 1'b0, out_rdy = 1'b0;
  logic [NB-1:0] in0_msg = '0, in1_msg = '0;
  logic          in0_rdy, in1_rdy, out_val, out_domain;
  logic [NB-1:0] out_msg;
  logic [7:0]    slot_cnt;
  // single-cycle-slot instance
  logic          s_in0_rdy, s_in1_rdy, s_out_val, s_out_domain;
  logic [NB-1:0] s_out_msg;
  logic [7:0]    s_slot_cnt;

  ring_tdm_arbiter #(.p_nbits(NB), .p_slot_cycles(P)) dut (
    .clk(clk), .reset(reset),
    .in0_val(in0_val), .in0_rdy(in0_rdy), .in0_msg(in0_msg),
    .in1_val(in1_val), .in1_rdy(in1_rdy), .in1_msg(in1_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
    .out_domain(out_domain), .slot_cnt(slot_cnt));

  ring_tdm_arbiter #(.p_nbits(NB), .p_slot_cycles(1)) dut1 (
    .clk(clk), .reset(reset),
    .in0_val(in0_val), .in0_rdy(s_in0_rdy), .in0_msg(in0_msg),
    .in1_val(in1_val), .in1_rdy(s_in1_rdy), .in1_msg(in1_msg),
    .out_val(s_out_val), .out_rdy(out_rdy), .out_msg(s_out_msg),
    .out_domain(s_out_domain), .slot_cnt(s_slot_cnt));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: absolute cycle count since reset gives the schedule,
  // two SV queues hold the per-domain FIFOs.
  logic [NB-1:0] mq0[$];
  logic [NB-1:0] mq1[$];
  int  mcyc = 0;
  bit  mvalid = 1'b0;
  int  md;
  bit  me0, me1, mdq;

  function automatic int m_dom();
    return (mcyc / P) % 2;
  endfunction

  function automatic int m_size(input int d);
    return (d == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic bit m_rdy(input int d);
    if (!reset) return 1'b1;
    return (m_size(d) < 2) || (m_dom() == d && out_rdy);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      mq0.delete();
      mq1.delete();
      mcyc   = 0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      md  = m_dom();
      me0 = in0_val && m_rdy(0);
      me1 = in1_val && m_rdy(1);
      mdq = out_rdy && (m_size(md) > 0);
      if (mdq) begin
        if (md == 0) void'(mq0.pop_front());
        else         void'(mq1.pop_front());
      end
      if (me0) mq0.push_back(in0_msg);
      if (me1) mq1.push_back(in1_msg);
      mcyc++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic          ev;
    logic [NB-1:0] em;
    if (mvalid) begin
      ev = reset && (m_size(m_dom()) > 0);
      em = '0;
      if (ev) em = (m_dom() == 0) ? mq0[0] : mq1[0];
      chk("m_out_val",    32'(out_val),    32'(ev));
      chk("m_out_msg",    out_msg,         em);
      chk("m_out_domain", 32'(out_domain), 32'(m_dom()));
      chk("m_slot_cnt",   32'(slot_cnt),   32'(mcyc % P));
      chk("m_in0_rdy",    32'(in0_rdy),    32'(m_rdy(0)));
      chk("m_in1_rdy",    32'(in1_rdy),    32'(m_rdy(1)));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 after reset release.
  task automatic do_reset();
    reset   = 1'b0;
    in0_val = 1'b0; in1_val = 1'b0; out_rdy = 1'b0;
    in0_msg = '0;   in1_msg = '0;
    next_cycle();
    reset = 1'b1;
  endtask

  int dtab [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  logic [9:0] tr_a [16];
  logic [9:0] tr_b [16];

  task automatic nonint_run(input bit busy1, output logic [9:0] tr [16]);
    do_reset();
    for (int c = 0; c < 16; c++) begin
      in0_val = (c % 3) != 2;
      in0_msg = 32'(c + 1);
      out_rdy = (c % 5) < 2;
      in1_val = busy1;
      in1_msg = 32'(100 + c);
      #1;
      tr[c] = {in0_rdy, out_domain, slot_cnt};
      next_cycle();
    end
    in0_val = 1'b0; in1_val = 1'b0; out_rdy = 1'b0;
  endtask

  initial begin
    // Idle schedule, plus single-cycle slot instance
    do_reset();
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("idle_dom",  32'(out_domain), 32'(dtab[c]));
      chk("idle_slot", 32'(slot_cnt),   32'(c % 4));
      chk("idle_val",  32'(out_val),    32'd0);
      chk("p1_dom",    32'(s_out_domain), 32'(c % 2));
      chk("p1_slot",   32'(s_slot_cnt),   32'd0);
      next_cycle();
    end

    // Domain 1 message waits for its slot
    do_reset();
    in1_val = 1'b1; in1_msg = 32'hAA; out_rdy = 1'b1;
    #1 chk("aa_in1_rdy", 32'(in1_rdy), 32'd1);
    next_cycle();
    in1_val = 1'b0;
    for (int c = 1; c < 4; c++) begin
      #1 chk("aa_wait_val", 32'(out_val), 32'd0);
      next_cycle();
    end
    #1;
    chk("aa_val", 32'(out_val),    32'd1);
    chk("aa_dom", 32'(out_domain), 32'd1);
    chk("aa_msg", out_msg,         32'hAA);
    next_cycle();
    #1 chk("aa_gone", 32'(out_val), 32'd0);

    // Domain 0 fills with link stalled
    do_reset();
    out_rdy = 1'b0;
    in0_val = 1'b1; in0_msg = 32'h1;
    #1 chk("f_rdy0", 32'(in0_rdy), 32'd1);
    next_cycle();
    in0_msg = 32'h2;
    #1 chk("f_rdy1", 32'(in0_rdy), 32'd1);
    next_cycle();
    in0_msg = 32'h3;
    #1;
    chk("f_rdy2",  32'(in0_rdy), 32'd0);
    chk("f_in1",   32'(in1_rdy), 32'd1);
    chk("f_head",  out_msg,      32'h1);
    next_cycle();
    in0_val = 1'b0;
    #1 chk("f_rdy3", 32'(in0_rdy), 32'd0);
    next_cycle();

    // Held head across foreign slot
    do_reset();
    in0_val = 1'b1; in0_msg = 32'h5;
    next_cycle();
    in0_msg = 32'h6;
    #1 chk("h_msg1", out_msg, 32'h5);
    next_cycle();
    in0_val = 1'b0;
    next_cycle();
    out_rdy = 1'b1;
    #1 chk("h_msg3", out_msg, 32'h5);
    next_cycle();
    out_rdy = 1'b0;
    for (int c = 4; c < 8; c++) begin
      #1 chk("h_foreign_val", 32'(out_val), 32'd0);
      next_cycle();
    end
    out_rdy = 1'b1;
    #1;
    chk("h_val8", 32'(out_val),    32'd1);
    chk("h_msg8", out_msg,         32'h6);
    chk("h_dom8", 32'(out_domain), 32'd0);
    next_cycle();
    out_rdy = 1'b0;
    #1 chk("h_val9", 32'(out_val), 32'd0);

    // Full queue with simultaneous enqueue and dequeue keeps order
    do_reset();
    in0_val = 1'b1; in0_msg = 32'h11;
    next_cycle();
    in0_msg = 32'h12;
    next_cycle();
    in0_msg = 32'h13; out_rdy = 1'b1;
    #1;
    chk("ed_rdy", 32'(in0_rdy), 32'd1);
    chk("ed_msg", out_msg,      32'h11);
    next_cycle();
    in0_val = 1'b0;
    #1 chk("ed_msg2", out_msg, 32'h12);
    next_cycle();
    out_rdy = 1'b0;
    for (int c = 4; c < 8; c++) next_cycle();
    #1 chk("ed_msg3", out_msg, 32'h13);
    next_cycle();

    // Reset mid-traffic
    do_reset();
    in0_val = 1'b1; in0_msg = 32'h21;
    in1_val = 1'b1; in1_msg = 32'h22;
    next_cycle();
    in0_val = 1'b0; in1_val = 1'b0;
    next_cycle();
    reset = 1'b0;
    #1;
    chk("r_during_val", 32'(out_val), 32'd0);
    chk("r_during_msg", out_msg,      32'd0);
    chk("r_during_rdy", 32'({in0_rdy, in1_rdy}), 32'd3);
    next_cycle();
    reset = 1'b1;
    #1;
    chk("r_val",  32'(out_val),    32'd0);
    chk("r_slot", 32'(slot_cnt),   32'd0);
    chk("r_dom",  32'(out_domain), 32'd0);
    chk("r_rdy",  32'({in0_rdy, in1_rdy}), 32'd3);
    for (int c = 0; c < 5; c++) next_cycle();
    #1 chk("r_q1_empty", 32'(out_val), 32'd0);

    // Domain 0 timing independent of domain 1 activity
    nonint_run(1'b0, tr_a);
    nonint_run(1'b1, tr_b);
    for (int c = 0; c < 16; c++) begin
      if (((c / P) % 2) == 0) chk("nonint", 32'(tr_b[c]), 32'(tr_a[c]));
    end

    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_tdm_arbiter.md
RING_TDM_ARBITER -- requirements
Module: ring_tdm_arbiter

Interface
REQ-001 Parameter p_nbits, default 32: message payload width in bits.
REQ-002 Parameter p_slot_cycles, default 4: cycles per domain time slot; legal range 1..255.
REQ-003 Port clk input 1: clock, all state updates on rising edge.
REQ-004 Port reset input 1: reset, synchronous, active-low; clock clk.
REQ-005 Ports in0_val input 1 / in0_rdy output 1 / in0_msg input p_nbits: domain-0 (L) requester, val/rdy handshake.
REQ-006 Ports in1_val input 1 / in1_rdy output 1 / in1_msg input p_nbits: domain-1 (H) requester, val/rdy handshake.
REQ-007 Ports out_val output 1 / out_rdy input 1 / out_msg output p_nbits: shared link toward ring, val/rdy handshake.
REQ-008 Port out_domain output 1: domain owning the current slot; tags out_msg.
REQ-009 Port slot_cnt output 8: cycle index within current slot, 0..p_slot_cycles-1.

Function
REQ-010 Transfer on any port occurs in a cycle where val and rdy are both 1 at the rising edge.
REQ-011 Per-domain 2-entry FIFO queue (q0, q1); each in_d port enqueues only into q_d.
REQ-012 in_d_rdy = 1 iff q_d count < 2, or q_d count == 2 and a dequeue from q_d occurs the same cycle.
REQ-013 in_d_rdy depends only on q_d occupancy, out_domain and out_rdy; never on the other domain's val, msg or occupancy.
REQ-014 Slot counter increments every cycle; at p_slot_cycles-1 it wraps to 0 and out_domain toggles the next cycle.
REQ-015 Slot schedule is fixed; slot switch never depends on request presence, queue occupancy or out_rdy (no work-conserving skip).
REQ-016 out_val = 1 iff q[out_domain] non-empty; out_msg = head of q[out_domain]; out_msg = 0 when out_val = 0.
REQ-017 Dequeue from q[out_domain] when out_val && out_rdy; the other queue is never dequeued in that cycle.
REQ-018 Minimum latency: message enqueued at edge t is visible on out_msg in cycle t+1 if out_domain matches; no combinational in->out bypass.
REQ-019 Simultaneous enqueue and dequeue on a full queue: count stays 2, order preserved.
REQ-020 Simultaneous enqueue and dequeue on an empty queue: impossible (out_val = 0); enqueue proceeds, count becomes 1.
REQ-021 Queue entries held across any number of foreign slots unchanged; FIFO order per domain strictly preserved.
REQ-022 Slot boundary with out_val && !out_rdy: head stays in q_d and is re-presented in domain d's next slot.
REQ-023 p_slot_cycles = 1: out_domain toggles every cycle; slot_cnt constant 0.
REQ-024 X on in_d_val or out_rdy while reset = 1 (deasserted) flagged by simulation assertion.

Reset
REQ-025 reset = 0 at a rising edge: both queues emptied, slot_cnt = 0, out_domain = 0.
REQ-026 During and after reset cycle: out_val = 0, out_msg = 0, in0_rdy = in1_rdy = 1 (queues empty).
REQ-027 Reset asserted mid-slot or mid-transfer discards queued messages; no handshake completes in the reset cycle.
REQ-028 First cycle after reset release is cycle 0 of a domain-0 slot.

Verification
REQ-029 Reset, p_slot_cycles=4, no traffic for 12 cycles -> out_domain 0,0,0,0,1,1,1,1,0,0,0,0; slot_cnt 0..3 repeating; out_val 0 throughout.
REQ-030 Cycle 0 enqueue in1_msg=0xAA, out_rdy=1 -> out_val 0 for cycles 1-3; out_val=1, out_domain=1, out_msg=0xAA in cycle 4; dequeued cycle 4.
REQ-031 Domain 0 enqueues 0x1,0x2,0x3 back-to-back with out_rdy=0 -> in0_rdy drops to 0 after 2 enqueues; 0x3 held at input; in1_rdy stays 1.
REQ-032 Domain 1 queue full and in1_val=1 continuously vs. idle domain 1 -> identical in0_rdy, out_domain, slot_cnt traces in domain 0 slots (noninterference).
REQ-033 q0 holds 0x5,0x6; out_rdy=1 only in cycle 3 -> 0x5 sent cycle 3, 0x6 held across domain-1 slot, sent cycle 8.
REQ-034 Both queues non-empty, reset=0 asserted in cycle 2 -> cycle 3: out_val=0, slot_cnt=0, out_domain=0, in0_rdy=in1_rdy=1.
